risc16_ctrl: RTL

Multi-cycle control FSM for the RiSC-16 core. It sequences fetch, decode, execute and memory phases. It drives the program counter's next-address select (`pc_sel`) and write enable, plus register file, ALU and memory strobes. It sits beside the PC, register file and ALU, and owns all state-advancing decisions, including halt and memory-timeout fault.

---
 rtl/risc16_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/risc16_ctrl.sv
// Multi-cycle RiSC-16 control FSM: FETCH -> DECODE -> EXEC [-> MEM], plus HALT on halt or memory timeout.
// Strobes are combinational from state/instr; halted, fault, retired and state are registered.
module risc16_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        mem_ready,
  input  logic        ops_eq,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_load,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic [1:0]  alu_op,
  output logic        alu_bsel,
  output logic        halted,
  output logic        fault,
  output logic [15:0] retired,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_e      state_q, state_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic [15:0] retired_q, retired_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  wait_nxt;
  logic [2:0]  opcode;
  logic        unused_instr_bits;

  assign opcode            = instr[15:13];
  assign wait_nxt          = wait_q + 8'd1;
  assign unused_instr_bits = ^instr[12:7];

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = 2'b00;
    rf_we        = 1'b0;
    rf_wsel      = 2'b00;
    alu_op       = 2'b00;
    alu_bsel     = 1'b0;
    state_d      = state_q;
    halted_d     = halted_q;
    fault_d      = fault_q;
    wait_d       = wait_q;

    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (WAIT_MAX != 8'd0 && wait_nxt == WAIT_MAX) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          fault_d  = 1'b1;
        end else begin
          wait_d = wait_nxt;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        wait_d  = 8'd0;
        unique case (opcode)
          OP_ADD, OP_ADDI, OP_NAND: begin
            alu_op   = (opcode == OP_NAND) ? 2'b01 : 2'b00;
            alu_bsel = (opcode == OP_ADDI);
            rf_we    = 1'b1;
            pc_en    = 1'b1;
          end
          OP_LUI: begin
            alu_op = 2'b10;
            rf_we  = 1'b1;
            pc_en  = 1'b1;
          end
          OP_SW, OP_LW: begin
            alu_bsel = 1'b1;
            state_d  = S_MEM;
          end
          OP_BEQ: begin
            pc_en  = 1'b1;
            pc_sel = ops_eq ? 2'b01 : 2'b00;
          end
          OP_JALR: begin
            // A nonzero low field turns JALR into the halt instruction.
            if (instr[6:0] == 7'd0) begin
              alu_op  = 2'b11;
              rf_we   = 1'b1;
              rf_wsel = 2'b10;
              pc_en   = 1'b1;
              pc_sel  = 2'b10;
            end else begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        alu_bsel     = 1'b1;
        mem_we       = (opcode == OP_SW);
        if (mem_ready) begin
          rf_we   = (opcode == OP_LW);
          rf_wsel = (opcode == OP_LW) ? 2'b01 : 2'b00;
          pc_en   = 1'b1;
          state_d = S_FETCH;
          wait_d  = 8'd0;
        end else if (WAIT_MAX != 8'd0 && wait_nxt == WAIT_MAX) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          fault_d  = 1'b1;
        end else begin
          wait_d = wait_nxt;
        end
      end
      default: ;
    endcase

    // Reset abandons whatever is in flight, so memory and the PC see nothing.
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_load      = 1'b0;
      pc_en        = 1'b0;
      pc_sel       = 2'b00;
      rf_we        = 1'b0;
      rf_wsel      = 2'b00;
      alu_op       = 2'b00;
      alu_bsel     = 1'b0;
    end

    retired_d = retired_q + {15'd0, pc_en};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      retired_q <= 16'd0;
      wait_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

  assign halted  = halted_q;
  assign fault   = fault_q;
  assign retired = retired_q;
  assign state   = state_q;

endmodule
